cgra_issue_ctrl: RTL and testbench

Instruction sequencer for one CGRA tile. It owns the program counter and fetches 32-bit instructions from the tile instruction memory. It presents each instruction to the ISA decoder and holds it there for the full element count of vector instructions. It resolves `bne` branches and tracks the vector-length code that `vsetivli` sets. It sits between the instruction memory and the decoder/vector datapath, and the host starts it with a single pulse.

---
 rtl/cgra_issue_ctrl.sv | 152 +++++++++++++++
 tb/tb_cgra_issue_ctrl.sv | 288 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/cgra_issue_ctrl.sv
// Instruction sequencer for one CGRA tile: fetch, issue, vector element stepping and bne resolution.
// Optional performance counters are built when CGRA_ISSUE_PERFCNT_EN is defined.
module cgra_issue_ctrl #(
  parameter int unsigned dwidth_inst  = 32,
  parameter int unsigned dwidth_RFadd = 12,
  parameter int unsigned PC_W         = 10
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    start,
  input  logic [PC_W-1:0]         prog_len,
  output logic                    imem_rd,
  output logic [PC_W-1:0]         imem_addr,
  input  logic [dwidth_inst-1:0]  imem_data,
  output logic [dwidth_inst-1:0]  instr,
  output logic                    instr_valid,
  input  logic                    is_not_vect,
  input  logic                    is_bne,
  input  logic [11:0]             branch_immediate,
  input  logic                    bne_taken,
  output logic                    vec_active,
  output logic [dwidth_RFadd-1:0] vec_idx,
  output logic                    busy,
  output logic                    done,
  output logic [31:0]             perf_cycles,
  output logic [31:0]             perf_instrs
);

  typedef enum logic [2:0] {StIdle, StFetch, StIssue, StVec, StFin} state_e;

  state_e                  state_q, state_d;
  logic [PC_W-1:0]         pc_q, pc_d, len_q, len_d;
  logic [dwidth_inst-1:0]  instr_q, instr_d;
  logic [2:0]              vlen_q, vlen_d;
  logic [dwidth_RFadd-1:0] idx_q, idx_d;

  logic [3:0]              vec_shamt;
  logic [dwidth_RFadd:0]   vec_len;
  logic [dwidth_RFadd-1:0] vec_last;
  logic                    vec_multi;
  logic signed [31:0]      pc_ext, len_ext, br_off, target;
  logic                    take, complete, in_range;

  // Element count N = depth_RF >> (vlen_code + 1)
  assign vec_shamt = {1'b0, vlen_q} + 4'd1;
  assign vec_len   = {1'b1, {dwidth_RFadd{1'b0}}} >> vec_shamt;
  assign vec_last  = dwidth_RFadd'(vec_len - (dwidth_RFadd + 1)'(1));
  assign vec_multi = vec_len > (dwidth_RFadd + 1)'(1);

  // Wide signed arithmetic so wrap-around below 0 or past 2^PC_W is caught as out of range
  assign pc_ext  = $signed({{(32 - PC_W){1'b0}}, pc_q});
  assign len_ext = $signed({{(32 - PC_W){1'b0}}, len_q});
  assign br_off  = $signed({{20{branch_immediate[11]}}, branch_immediate}) >>> 1;

  assign imem_rd     = (state_q == StFetch);
  assign imem_addr   = imem_rd ? pc_q : '0;
  assign instr_valid = (state_q == StIssue);
  // Read data bypasses the register in ISSUE so the decoder sees it in the first issue cycle
  assign instr       = instr_valid ? imem_data : instr_q;
  assign vec_active  = (state_q == StVec) || (instr_valid && !is_not_vect);
  assign vec_idx     = (state_q == StVec) ? idx_q : '0;
  assign busy        = (state_q != StIdle);
  assign done        = (state_q == StFin);

  always_comb begin
    state_d  = state_q;
    pc_d     = pc_q;
    len_d    = len_q;
    instr_d  = instr_q;
    vlen_d   = vlen_q;
    idx_d    = idx_q;
    take     = 1'b0;
    complete = 1'b0;
    target   = '0;
    in_range = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (start) begin
          len_d   = prog_len;
          pc_d    = '0;
          state_d = (prog_len == '0) ? StFin : StFetch;
        end
      end
      StFetch: state_d = StIssue;
      StIssue: begin
        instr_d = imem_data;
        if (imem_data[6:0] == 7'h57 && imem_data[14:12] == 3'd7) vlen_d = imem_data[17:15];
        if (!is_not_vect && vec_multi) begin
          state_d = StVec;
          idx_d   = dwidth_RFadd'(1);
        end else begin
          complete = 1'b1;
          take     = is_not_vect && is_bne && bne_taken;
        end
      end
      StVec: begin
        if (idx_q == vec_last) complete = 1'b1;
        else idx_d = idx_q + dwidth_RFadd'(1);
      end
      StFin:   state_d = StIdle;
      default: state_d = StIdle;
    endcase

    if (complete) begin
      target   = pc_ext + (take ? br_off : 32'sd1);
      in_range = (target >= 32'sd0) && (target < len_ext);
      pc_d     = target[PC_W-1:0];
      idx_d    = '0;
      state_d  = in_range ? StFetch : StFin;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= StIdle;
      pc_q    <= '0;
      len_q   <= '0;
      instr_q <= '0;
      vlen_q  <= '0;
      idx_q   <= '0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      len_q   <= len_d;
      instr_q <= instr_d;
      vlen_q  <= vlen_d;
      idx_q   <= idx_d;
    end
  end

`ifdef CGRA_ISSUE_PERFCNT_EN
  logic [31:0] perf_cycles_q, perf_instrs_q;

  always_ff @(posedge clk) begin
    if (!rst || (state_q == StIdle && start)) begin
      perf_cycles_q <= '0;
      perf_instrs_q <= '0;
    end else begin
      if (busy && perf_cycles_q != '1) perf_cycles_q <= perf_cycles_q + 32'd1;
      if (instr_valid && perf_instrs_q != '1) perf_instrs_q <= perf_instrs_q + 32'd1;
    end
  end

  assign perf_cycles = perf_cycles_q;
  assign perf_instrs = perf_instrs_q;
`else
  assign perf_cycles = '0;
  assign perf_instrs = '0;
`endif

endmodule

// File: tb/tb_cgra_issue_ctrl.sv
// Bench for cgra_issue_ctrl: an instruction-level program interpreter builds a per-cycle expected
// timeline that is compared against the controller on directed and random programs.
module tb_cgra_issue_ctrl;

  localparam int MaxC = 16384;

  typedef struct packed {
    logic        rd;
    logic [9:0]  addr;
    logic        iv;
    logic        va;
    logic [11:0] idx;
    logic        busy;
    logic        done;
  } cyc_t;

  logic        clk, rst, start;
  logic [9:0]  prog_len;
  logic        imem_rd;
  logic [9:0]  imem_addr;
  logic [31:0] imem_data;
  logic [31:0] instr;
  logic        instr_valid, is_not_vect, is_bne, bne_taken;
  logic [11:0] branch_immediate;
  logic        vec_active;
  logic [11:0] vec_idx;
  logic        busy, done;
  logic [31:0] perf_cycles, perf_instrs;

  logic [31:0] mem [0:1023];
  cyc_t        exp_c [0:MaxC-1];
  logic [31:0] exp_i [0:MaxC-1];
  bit          taken_arr [0:15];
  int          taken_n = 0;
  int          bne_cnt = 0;
  int          bne_base = 0;
  int          bne_idx;
  int          m_vlen = 0;
  int          n_total = 0;
  int          n_bad = 0;

  cgra_issue_ctrl dut (
    .clk              (clk),
    .rst              (rst),
    .start            (start),
    .prog_len         (prog_len),
    .imem_rd          (imem_rd),
    .imem_addr        (imem_addr),
    .imem_data        (imem_data),
    .instr            (instr),
    .instr_valid      (instr_valid),
    .is_not_vect      (is_not_vect),
    .is_bne           (is_bne),
    .branch_immediate (branch_immediate),
    .bne_taken        (bne_taken),
    .vec_active       (vec_active),
    .vec_idx          (vec_idx),
    .busy             (busy),
    .done             (done),
    .perf_cycles      (perf_cycles),
    .perf_instrs      (perf_instrs)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) if (imem_rd) imem_data <= mem[imem_addr];
  always @(posedge clk) if (instr_valid && is_bne) bne_cnt <= bne_cnt + 1;

  // Toy decoder: bne immediate lives in instr[31:20]
  assign is_bne           = (instr[6:0] == 7'h63);
  assign is_not_vect      = !(instr[6:0] == 7'h57 && instr[14:12] != 3'd7);
  assign branch_immediate = instr[31:20];
  assign bne_idx          = bne_cnt - bne_base;
  assign bne_taken        = (bne_idx >= 0 && bne_idx < taken_n) ? taken_arr[bne_idx[3:0]] : 1'b0;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] want);
    n_total++;
    if (got !== want) begin
      n_bad++;
      $display("FAIL %s got=%h want=%h", tag, got, want);
    end
  endtask

  function automatic logic [31:0] enc_addi();
    return ($urandom & 32'hFFFF_FF80) | 32'h13;
  endfunction
  function automatic logic [31:0] enc_bne(input logic [11:0] imm);
    return {imm, 5'd0, 3'd1, 5'd0, 7'h63};
  endfunction
  function automatic logic [31:0] enc_vset(input logic [2:0] v);
    return {12'h0, 2'b0, v, 3'd7, 5'd1, 7'h57};
  endfunction
  function automatic logic [31:0] enc_vop();
    return {17'h0, 3'd2, 5'd3, 7'h57};
  endfunction

  // Instruction-level interpreter producing the expected cycle timeline (cycle 0 = start cycle)
  function automatic void build_model(input int len, output int done_c, output int n_iss);
    int t, pc, nxt, tk, n, off;
    logic [31:0] w;
    bit take;
    for (int c = 0; c < MaxC; c++) begin
      exp_c[c] = '0;
      exp_i[c] = '0;
    end
    t = 0; pc = 0; tk = 0; n_iss = 0;
    while (pc < len && t < MaxC - 2100) begin
      w = mem[pc];
      t++;
      exp_c[t].rd = 1'b1; exp_c[t].addr = pc[9:0]; exp_c[t].busy = 1'b1;
      t++;
      exp_c[t].iv = 1'b1; exp_c[t].busy = 1'b1; exp_i[t] = w;
      n_iss++;
      nxt = pc + 1;
      if (w[6:0] == 7'h57 && w[14:12] == 3'd7) begin
        m_vlen = int'(w[17:15]);
      end else if (w[6:0] == 7'h57) begin
        n = 4096 >> (m_vlen + 1);
        for (int k = 0; k < n; k++) begin
          exp_c[t+k].va = 1'b1; exp_c[t+k].idx = k[11:0]; exp_c[t+k].busy = 1'b1;
          exp_i[t+k] = w;
        end
        t += n - 1;
      end else if (w[6:0] == 7'h63) begin
        take = (tk < taken_n) ? taken_arr[tk] : 1'b0;
        tk++;
        if (take) begin
          off = int'($signed(w[31:20]));
          nxt = pc + (off >>> 1);
        end
      end
      if (nxt < 0 || nxt >= 1024) break;
      pc = nxt;
    end
    done_c = t + 1;
    exp_c[done_c].done = 1'b1;
    exp_c[done_c].busy = 1'b1;
  endfunction

  function automatic cyc_t sample();
    cyc_t s;
    s.rd   = imem_rd;
    s.addr = imem_rd ? imem_addr : 10'd0;
    s.iv   = instr_valid;
    s.va   = vec_active;
    s.idx  = vec_active ? vec_idx : 12'd0;
    s.busy = busy;
    s.done = done;
    return s;
  endfunction

  task automatic run_prog(input string name, input int len, input bit poke);
    int done_c, n_iss;
    cyc_t obs;
    build_model(len, done_c, n_iss);
    bne_base = bne_cnt;
    @(negedge clk);
    prog_len = len[9:0];
    start    = 1'b1;
    @(negedge clk);
    for (int c = 1; c <= done_c + 1; c++) begin
      start    = poke && (c == 3);
      prog_len = 10'($urandom);
      obs      = sample();
      if (n_bad < 40) begin
        check_eq($sformatf("%s.sig@%0d", name, c), {37'b0, obs}, {37'b0, exp_c[c]});
        if (exp_c[c].iv || exp_c[c].va)
          check_eq($sformatf("%s.instr@%0d", name, c), {32'b0, instr}, {32'b0, exp_i[c]});
      end
      if (c <= done_c) @(negedge clk);
    end
    start = 1'b0;
`ifdef CGRA_ISSUE_PERFCNT_EN
    check_eq({name, ".perf_cycles"}, {32'b0, perf_cycles}, {32'b0, 32'(done_c)});
    check_eq({name, ".perf_instrs"}, {32'b0, perf_instrs}, {32'b0, 32'(n_iss)});
`else
    check_eq({name, ".perf_cycles"}, {32'b0, perf_cycles}, 64'd0);
    check_eq({name, ".perf_instrs"}, {32'b0, perf_instrs}, 64'd0);
`endif
  endtask

  function automatic logic [63:0] all_outs();
    return {5'b0, imem_rd, imem_addr, instr, instr_valid, vec_active, vec_idx, busy, done};
  endfunction

  task automatic reset_mid_vec();
    bit found;
    mem[0] = enc_vset(3'd5);
    mem[1] = enc_vop();
    mem[2] = enc_addi();
    @(negedge clk);
    prog_len = 10'd3;
    start    = 1'b1;
    @(negedge clk);
    start = 1'b0;
    found = 1'b0;
    for (int i = 0; i < 200 && !found; i++) begin
      if (vec_active && vec_idx == 12'd10) found = 1'b1;
      else @(negedge clk);
    end
    check_eq("rst_wait_idx10", {63'b0, found}, 64'd1);
    rst = 1'b0;
    @(negedge clk);
    check_eq("rst_abort_outs", all_outs(), 64'd0);
    check_eq("rst_abort_perf", {perf_cycles, perf_instrs}, 64'd0);
    rst    = 1'b1;
    m_vlen = 0;
  endtask

  task automatic rand_prog(output int len);
    int r, off;
    len = int'($urandom_range(12, 2));
    mem[0] = enc_vset(3'($urandom_range(7, 4)));
    for (int i = 1; i < len; i++) begin
      r = int'($urandom_range(9, 0));
      if (r == 5 || r == 6) begin
        off = int'($urandom_range(28, 0)) - 14;
        mem[i] = enc_bne(12'(off));
      end else if (r == 7) begin
        mem[i] = enc_vop();
      end else if (r == 8) begin
        mem[i] = enc_vset(3'($urandom_range(7, 4)));
      end else begin
        mem[i] = enc_addi();
      end
    end
    for (int i = len; i < len + 24; i++) mem[i] = $urandom;
    taken_n = int'($urandom_range(6, 0));
    for (int i = 0; i < 16; i++) taken_arr[i] = 1'($urandom_range(1, 0));
  endtask

  initial begin
    int len;
    for (int i = 0; i < 1024; i++) mem[i] = 32'h0000_0013;
    rst      = 1'b0;
    start    = 1'b0;
    prog_len = '0;
    repeat (3) @(negedge clk);
    check_eq("reset_outs", all_outs(), 64'd0);
    check_eq("reset_perf", {perf_cycles, perf_instrs}, 64'd0);
    rst = 1'b1;

    for (int i = 0; i < 3; i++) mem[i] = enc_addi();
    taken_n = 0;
    run_prog("straight", 3, 1'b0);

    mem[0] = enc_vset(3'd5);
    mem[1] = enc_vop();
    mem[2] = enc_addi();
    run_prog("vec64_busy_start", 3, 1'b1);

    for (int i = 0; i < 4; i++) mem[i] = enc_addi();
    mem[4] = enc_bne(12'hFF8);
    mem[5] = enc_addi();
    taken_arr[0] = 1'b1; taken_arr[1] = 1'b1; taken_n = 2;
    run_prog("bne_loop", 6, 1'b0);

    mem[0] = enc_addi();
    mem[1] = enc_bne(12'd20);
    taken_arr[0] = 1'b1; taken_n = 1;
    run_prog("bne_out_of_range", 2, 1'b0);

    mem[0] = enc_bne(12'hFFC);
    mem[1] = enc_addi();
    mem[2] = enc_addi();
    taken_arr[0] = 1'b1; taken_n = 1;
    run_prog("bne_wrap", 3, 1'b0);

    taken_n = 0;
    run_prog("len_zero", 0, 1'b0);

    reset_mid_vec();

    mem[0] = enc_addi();
    mem[1] = enc_vop();
    run_prog("vec2048_after_rst", 2, 1'b0);

    for (int k = 0; k < 6; k++) begin
      rand_prog(len);
      run_prog($sformatf("rand%0d", k), len, 1'(k % 2));
    end

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
